// File: rtl/guitar_pkg.sv
// Shared types for the note-highway scroll logic: scheduler states and speed codes.
package guitar_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COUNTDOWN = 3'd1,
      PLAYING   = 3'd2,
      PAUSED    = 3'd3,
      DONE      = 3'd4
   } scroll_state_t;

   localparam logic [1:0] SPD_X1 = 2'd0;
   localparam logic [1:0] SPD_X2 = 2'd1;
   localparam logic [1:0] SPD_X4 = 2'd2;
   localparam logic [1:0] SPD_X8 = 2'd3;

endpackage

// File: rtl/tick_divider.sv
// Reloadable down-counter: raises tick while running and at zero, then reloads period.
module tick_divider #(
   parameter int DIV_W = 27
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             run,
   input  logic [DIV_W-1:0] period,
   output logic             tick
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] cnt;

   assign tick = run && (cnt == '0);

   // load wins over run so the scheduler can zero the counter on the final tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= period;
      end else if (run) begin
         cnt <= (cnt == '0) ? period : cnt - ONE;
      end
   end

endmodule

// File: rtl/note_scroll_scheduler.sv
// Scroll sequencer for one song: countdown, stepped note position, pause/resume, end detect.
module note_scroll_scheduler
   import guitar_pkg::*;
#(
   parameter int SLOW_DIV = 50_000_000,
   parameter int DIV_W    = 27,
   parameter int POS_W    = 7,
   parameter int SONG_LEN = 100,
   parameter int CD_TICKS = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             pause,
   input  logic [1:0]       speed,
   output logic             step_en,
   output logic [POS_W-1:0] pos,
   output logic [15:0]      step_cnt,
   output logic [1:0]       countdown,
   output logic [2:0]       state,
   output logic             done
);

   localparam logic [DIV_W-1:0] PER_X1 = DIV_W'(SLOW_DIV - 1);
   localparam logic [DIV_W-1:0] PER_X2 = DIV_W'((SLOW_DIV >> 1) - 1);
   localparam logic [DIV_W-1:0] PER_X4 = DIV_W'((SLOW_DIV >> 2) - 1);
   localparam logic [DIV_W-1:0] PER_X8 = DIV_W'((SLOW_DIV >> 3) - 1);
   localparam logic [15:0]      LAST_STEP = 16'(SONG_LEN - 1);
   localparam logic [15:0]      CNT_ONE   = 16'd1;
   localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
   localparam logic [1:0]       CD_INIT   = 2'(CD_TICKS);

   scroll_state_t    state_q, state_d;
   logic [1:0]       cd_d;
   logic [POS_W-1:0] pos_d;
   logic [15:0]      cnt_d;
   logic             step_d;
   logic             div_load, div_run, tick;
   logic [DIV_W-1:0] reload_val, div_period;

   assign state   = state_q;
   assign div_run = (state_q == COUNTDOWN) || (state_q == PLAYING);

   always_comb begin
      reload_val = PER_X1;
      case (speed)
         SPD_X1:  reload_val = PER_X1;
         SPD_X2:  reload_val = PER_X2;
         SPD_X4:  reload_val = PER_X4;
         SPD_X8:  reload_val = PER_X8;
         default: reload_val = PER_X1;
      endcase
   end

   tick_divider #(.DIV_W(DIV_W)) u_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (div_load),
      .run    (div_run),
      .period (div_period),
      .tick   (tick)
   );

   // Next-state logic; entering DONE reloads the divider with zero so it rests at 0
   always_comb begin
      state_d    = state_q;
      cd_d       = countdown;
      pos_d      = pos;
      cnt_d      = step_cnt;
      step_d     = 1'b0;
      div_load   = 1'b0;
      div_period = reload_val;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = COUNTDOWN;
               cd_d     = CD_INIT;
               pos_d    = '0;
               cnt_d    = '0;
               div_load = 1'b1;
            end
         end
         COUNTDOWN: begin
            if (tick) begin
               if (countdown == 2'd1) begin
                  state_d = PLAYING;
                  cd_d    = 2'd0;
               end else begin
                  cd_d = countdown - 2'd1;
               end
            end
         end
         PLAYING: begin
            if (tick) begin
               step_d = 1'b1;
               pos_d  = pos + POS_ONE;
               cnt_d  = step_cnt + CNT_ONE;
               if (step_cnt == LAST_STEP) begin
                  state_d    = DONE;
                  div_load   = 1'b1;
                  div_period = '0;
               end else if (pause) begin
                  state_d = PAUSED;
               end
            end else if (pause) begin
               state_d = PAUSED;
            end
         end
         PAUSED: begin
            if (pause) begin
               state_d = PLAYING;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         countdown <= 2'd0;
         pos       <= '0;
         step_cnt  <= '0;
         step_en   <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         countdown <= cd_d;
         pos       <= pos_d;
         step_cnt  <= cnt_d;
         step_en   <= step_d;
         done      <= (state_d == DONE);
      end
   end

endmodule

// File: tb/tb_note_scroll_scheduler.sv
// Directed bench for note_scroll_scheduler; step_en pulses are checked against a scoreboard.
module tb_note_scroll_scheduler;
   import guitar_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        pause;
   logic [1:0]  speed;
   logic        step_en;
   logic [6:0]  pos;
   logic [15:0] step_cnt;
   logic [1:0]  countdown;
   logic [2:0]  state;
   logic        done;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      int          edge_n;
      logic [6:0]  pos;
      logic [15:0] cnt;
   } step_t;

   step_t exp_q[$];

   note_scroll_scheduler #(
      .SLOW_DIV (8),
      .DIV_W    (4),
      .POS_W    (7),
      .SONG_LEN (5),
      .CD_TICKS (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .pause     (pause),
      .speed     (speed),
      .step_en   (step_en),
      .pos       (pos),
      .step_cnt  (step_cnt),
      .countdown (countdown),
      .state     (state),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic pushStep(input int e, input int p, input int c);
      step_t s;
      s.edge_n = e;
      s.pos    = 7'(p);
      s.cnt    = 16'(c);
      exp_q.push_back(s);
   endtask

   // Drives one-cycle pulses from a negedge; returns the posedge number that samples them
   task automatic applyStimulus(input logic st, input logic pa, output int e);
      start = st;
      pause = pa;
      e     = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      pause = 1'b0;
   endtask

   task automatic waitEdge(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   // Every step_en pulse must match the next queued expectation in edge, pos and count
   always @(negedge clk) begin
      if (rst_n && step_en) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_step_en_at_edge", 32'(cyc), 32'd0);
         end else begin
            step_t s;
            s = exp_q.pop_front();
            checkOutput("step_edge", 32'(cyc), 32'(s.edge_n));
            checkOutput("step_pos", 32'(pos), 32'(s.pos));
            checkOutput("step_cnt", 32'(step_cnt), 32'(s.cnt));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   int s;
   int e;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      speed = SPD_X1;
      repeat (3) @(negedge clk);
      checkOutput("reset_state", 32'(state), 32'(IDLE));
      checkOutput("reset_pos", 32'(pos), 32'd0);
      checkOutput("reset_step_cnt", 32'(step_cnt), 32'd0);
      checkOutput("reset_countdown", 32'(countdown), 32'd0);
      checkOutput("reset_step_en", 32'(step_en), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] song 1: countdown and full run");
      applyStimulus(1'b1, 1'b0, s);
      for (int k = 1; k <= 5; k++) pushStep(s + 32 + 8 * (k - 1), k, k);
      checkOutput("cd_state", 32'(state), 32'(COUNTDOWN));
      checkOutput("cd_3", 32'(countdown), 32'd3);
      waitEdge(s + 7);
      checkOutput("cd_3_hold", 32'(countdown), 32'd3);
      waitEdge(s + 8);
      checkOutput("cd_2", 32'(countdown), 32'd2);
      waitEdge(s + 16);
      checkOutput("cd_1", 32'(countdown), 32'd1);
      waitEdge(s + 24);
      checkOutput("cd_0", 32'(countdown), 32'd0);
      checkOutput("playing_state", 32'(state), 32'(PLAYING));
      waitEdge(s + 64);
      checkOutput("done_state", 32'(state), 32'(DONE));
      checkOutput("done_flag", 32'(done), 32'd1);
      checkOutput("done_pos", 32'(pos), 32'd5);
      checkOutput("done_step_cnt", 32'(step_cnt), 32'd5);
      waitEdge(s + 90);
      checkOutput("done_hold_state", 32'(state), 32'(DONE));

      $display("[TB] song 2: restart from DONE, pause and speed change");
      applyStimulus(1'b1, 1'b0, s);
      checkOutput("restart_pos", 32'(pos), 32'd0);
      checkOutput("restart_step_cnt", 32'(step_cnt), 32'd0);
      checkOutput("restart_done", 32'(done), 32'd0);
      pushStep(s + 32, 1, 1);
      waitEdge(s + 34);
      applyStimulus(1'b0, 1'b1, e);
      checkOutput("paused_state", 32'(state), 32'(PAUSED));
      waitEdge(e + 19);
      checkOutput("paused_pos_held", 32'(pos), 32'd1);
      checkOutput("paused_cnt_held", 32'(step_cnt), 32'd1);
      applyStimulus(1'b0, 1'b1, e);
      checkOutput("resumed_state", 32'(state), 32'(PLAYING));
      pushStep(e + 5, 2, 2);
      waitEdge(e + 5);
      speed = SPD_X4;
      pushStep(e + 13, 3, 3);
      pushStep(e + 15, 4, 4);
      pushStep(e + 17, 5, 5);
      waitEdge(e + 17);
      checkOutput("fast_done_state", 32'(state), 32'(DONE));

      $display("[TB] song 3: async reset mid-PLAYING");
      applyStimulus(1'b1, 1'b0, s);
      pushStep(s + 8, 1, 1);
      waitEdge(s + 9);
      checkOutput("pre_reset_state", 32'(state), 32'(PLAYING));
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_state", 32'(state), 32'(IDLE));
      checkOutput("rst_mid_pos", 32'(pos), 32'd0);
      checkOutput("rst_mid_step_cnt", 32'(step_cnt), 32'd0);
      checkOutput("rst_mid_step_en", 32'(step_en), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      speed = SPD_X1;
      @(negedge clk);

      $display("[TB] song 4: position wrap, ignored start, pause on final step");
      applyStimulus(1'b1, 1'b0, s);
      force dut.pos = 7'd126;
      @(negedge clk);
      release dut.pos;
      waitEdge(s + 10);
      checkOutput("preload_pos", 32'(pos), 32'd126);
      pushStep(s + 32, 127, 1);
      pushStep(s + 40, 0, 2);
      pushStep(s + 48, 1, 3);
      pushStep(s + 56, 2, 4);
      pushStep(s + 64, 3, 5);
      waitEdge(s + 35);
      applyStimulus(1'b1, 1'b0, e);
      checkOutput("ignored_start_state", 32'(state), 32'(PLAYING));
      checkOutput("ignored_start_cnt", 32'(step_cnt), 32'd1);
      checkOutput("ignored_start_pos", 32'(pos), 32'd127);
      waitEdge(s + 63);
      applyStimulus(1'b0, 1'b1, e);
      checkOutput("final_pause_state", 32'(state), 32'(DONE));
      checkOutput("final_pause_done", 32'(done), 32'd1);
      checkOutput("wrap_final_pos", 32'(pos), 32'd3);
      repeat (4) @(negedge clk);
      applyStimulus(1'b1, 1'b0, s);
      checkOutput("done_restart_state", 32'(state), 32'(COUNTDOWN));
      checkOutput("done_restart_pos", 32'(pos), 32'd0);
      checkOutput("done_restart_cnt", 32'(step_cnt), 32'd0);
      checkOutput("done_restart_cd", 32'(countdown), 32'd3);
      repeat (4) @(negedge clk);

      checkOutput("missing_steps", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
